// File: rtl/pipeline_pkg.sv
// Shared definitions for the writeback/retire stage: exception layout,
// exc_code sizing, FSM state and write-source encodings.
package pipeline_pkg;

  // Default exception vector layout, MSB to LSB: {decode, alu, mem}
  localparam int DEC_EXC_W_DEF = 1;
  localparam int ALU_EXC_W_DEF = 3;
  localparam int MEM_EXC_W_DEF = 3;
  localparam int EXC_W_DEF     = DEC_EXC_W_DEF + ALU_EXC_W_DEF + MEM_EXC_W_DEF;

  // Bit positions of each field for the default layout
  localparam int MEM_EXC_LSB = 0;
  localparam int ALU_EXC_LSB = MEM_EXC_LSB + MEM_EXC_W_DEF;
  localparam int DEC_EXC_LSB = ALU_EXC_LSB + ALU_EXC_W_DEF;

  // exc_code holds 0 (none) or 1..EXC_W
  function automatic int exc_code_w(input int exc_w);
    return $clog2(exc_w + 1);
  endfunction

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_TRAPPED = 1'b1
  } wb_state_e;

  typedef enum logic [1:0] {
    SRC_ALU     = 2'd0,
    SRC_MEM     = 2'd1,
    SRC_LATEALU = 2'd2
  } wb_src_e;

endpackage

// File: rtl/pipeline_writeback_if.sv
// Writeback bus: instruction/result inputs from the pipeline and the
// regfile write port, forwarding tap and trap record going out.
interface pipeline_writeback_if
  import pipeline_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RIDX_W    = 5,
  parameter int DEC_EXC_W = 1,
  parameter int ALU_EXC_W = 3,
  parameter int MEM_EXC_W = 3,
  parameter int CNT_W     = 32
);
  localparam int EXC_W  = DEC_EXC_W + ALU_EXC_W + MEM_EXC_W;
  localparam int CODE_W = exc_code_w(EXC_W);

  logic                 valid_in;
  logic [DATA_W-1:0]    pc_in;
  logic [DEC_EXC_W-1:0] decode_exception;
  logic [ALU_EXC_W-1:0] alu_exception;
  logic [MEM_EXC_W-1:0] mem_exception;
  logic [RIDX_W-1:0]    rd_index;
  logic                 regwrite_enable;
  logic                 memread_enable;
  logic                 memop_disable;
  logic                 latealu_enable;
  logic [DATA_W-1:0]    latealu_result;
  logic [DATA_W-1:0]    alu_out;
  logic [DATA_W-1:0]    mem_out;
  logic                 exc_ack;

  logic [EXC_W-1:0]     final_exception;
  logic [CODE_W-1:0]    exc_code;
  logic                 exc_pending;
  logic [DATA_W-1:0]    exc_pc;
  logic                 flush;
  logic                 we;
  logic [RIDX_W-1:0]    windex;
  logic [DATA_W-1:0]    win;
  logic                 fwd_valid;
  logic [RIDX_W-1:0]    fwd_index;
  logic [DATA_W-1:0]    fwd_data;
  logic [CNT_W-1:0]     retire_count;

  modport master (
    output valid_in, pc_in, decode_exception, alu_exception, mem_exception,
           rd_index, regwrite_enable, memread_enable, memop_disable,
           latealu_enable, latealu_result, alu_out, mem_out, exc_ack,
    input  final_exception, exc_code, exc_pending, exc_pc, flush,
           we, windex, win, fwd_valid, fwd_index, fwd_data, retire_count
  );

  modport slave (
    input  valid_in, pc_in, decode_exception, alu_exception, mem_exception,
           rd_index, regwrite_enable, memread_enable, memop_disable,
           latealu_enable, latealu_result, alu_out, mem_out, exc_ack,
    output final_exception, exc_code, exc_pending, exc_pc, flush,
           we, windex, win, fwd_valid, fwd_index, fwd_data, retire_count
  );

endinterface

// File: rtl/pipeline_writeback_exc_priority_enc.sv
// Priority encoder: 1 + index of the highest set exception bit, 0 if none.
module exc_priority_enc
  import pipeline_pkg::*;
#(
  parameter int EXC_W  = EXC_W_DEF,
  parameter int CODE_W = exc_code_w(EXC_W)
) (
  input  logic [EXC_W-1:0]  exc,
  output logic [CODE_W-1:0] code
);

  // Ascending scan so the highest set bit is the last to win
  always_comb begin
    code = '0;
    for (int i = 0; i < EXC_W; i++) begin
      if (exc[i]) code = CODE_W'(i + 1);
    end
  end

endmodule

// File: rtl/pipeline_writeback.sv
// Writeback/retire stage: selects the regfile write source, captures the
// first exception into a sticky trap record, and counts retired instructions.
module pipeline_writeback
  import pipeline_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RIDX_W    = 5,
  parameter int DEC_EXC_W = 1,
  parameter int ALU_EXC_W = 3,
  parameter int MEM_EXC_W = 3,
  parameter int REG_OUT   = 0,
  parameter int CNT_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_writeback_if.slave bus
);

  localparam int EXC_W  = DEC_EXC_W + ALU_EXC_W + MEM_EXC_W;
  localparam int CODE_W = exc_code_w(EXC_W);

  wb_state_e         state_q, state_d;
  logic [EXC_W-1:0]  exc_lat_q, exc_lat_d;
  logic [DATA_W-1:0] exc_pc_q, exc_pc_d;
  logic              exc_pending_q, exc_pending_d;
  logic [CNT_W-1:0]  retire_q, retire_d;

  logic [EXC_W-1:0]  exc_in;
  logic [EXC_W-1:0]  final_exc;
  logic              is_idle;
  logic              capture;
  logic              wr;
  wb_src_e           src;
  logic [DATA_W-1:0] wdata;

  // Incoming exceptions, fast-path final vector and the capture condition
  always_comb begin
    exc_in    = bus.valid_in ? {bus.decode_exception, bus.alu_exception, bus.mem_exception}
                             : '0;
    is_idle   = (state_q == ST_IDLE);
    final_exc = is_idle ? exc_in : exc_lat_q;
    capture   = is_idle && (exc_in != '0);
  end

  // Trap FSM: first exception wins; ack only matters once trapped, so a
  // capture cycle with ack high still captures
  always_comb begin
    state_d       = state_q;
    exc_lat_d     = exc_lat_q;
    exc_pc_d      = exc_pc_q;
    exc_pending_d = exc_pending_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d       = ST_TRAPPED;
          exc_lat_d     = exc_in;
          exc_pc_d      = bus.pc_in;
          exc_pending_d = 1'b1;
        end
      end
      ST_TRAPPED: begin
        if (bus.exc_ack) begin
          state_d       = ST_IDLE;
          exc_lat_d     = '0;
          exc_pc_d      = '0;
          exc_pending_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Retire counter: clean valid instructions in IDLE, wraps naturally
  always_comb begin
    retire_d = retire_q;
    if (bus.valid_in && (final_exc == '0) && is_idle) retire_d = retire_q + CNT_W'(1);
  end

  // Write source select and write qualification
  always_comb begin
    if (bus.latealu_enable)                          src = SRC_LATEALU;
    else if (bus.memread_enable && !bus.memop_disable) src = SRC_MEM;
    else                                             src = SRC_ALU;
    case (src)
      SRC_LATEALU: wdata = bus.latealu_result;
      SRC_MEM:     wdata = bus.mem_out;
      default:     wdata = bus.alu_out;
    endcase
    wr = bus.valid_in && bus.regwrite_enable && (final_exc == '0)
         && (bus.rd_index != '0) && is_idle;
  end

  // Trap record and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      exc_lat_q     <= '0;
      exc_pc_q      <= '0;
      exc_pending_q <= 1'b0;
      retire_q      <= '0;
    end else begin
      state_q       <= state_d;
      exc_lat_q     <= exc_lat_d;
      exc_pc_q      <= exc_pc_d;
      exc_pending_q <= exc_pending_d;
      retire_q      <= retire_d;
    end
  end

  exc_priority_enc #(.EXC_W(EXC_W), .CODE_W(CODE_W)) u_enc (
    .exc  (final_exc),
    .code (bus.exc_code)
  );

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic              we_q, we_d;
      logic [RIDX_W-1:0] windex_q, windex_d;
      logic [DATA_W-1:0] win_q, win_d;

      // Next-cycle write port values
      always_comb begin
        we_d     = wr;
        windex_d = bus.rd_index;
        win_d    = wdata;
      end

      // Registered write port; reset drops any in-flight write
      always_ff @(posedge clk) begin
        if (rst) begin
          we_q     <= 1'b0;
          windex_q <= '0;
          win_q    <= '0;
        end else begin
          we_q     <= we_d;
          windex_q <= windex_d;
          win_q    <= win_d;
        end
      end

      assign bus.we     = we_q;
      assign bus.windex = windex_q;
      assign bus.win    = win_q;
    end else begin : g_comb_out
      assign bus.we     = wr;
      assign bus.windex = bus.rd_index;
      assign bus.win    = wdata;
    end
  endgenerate

  assign bus.final_exception = final_exc;
  assign bus.flush           = capture;
  assign bus.exc_pending     = exc_pending_q;
  assign bus.exc_pc          = exc_pc_q;
  assign bus.retire_count    = retire_q;
  assign bus.fwd_valid       = bus.we;
  assign bus.fwd_index       = bus.windex;
  assign bus.fwd_data        = bus.win;

endmodule

// File: tb/tb_pipeline_writeback.sv
// Bench for pipeline_writeback: drives a combinational-port and a
// registered-port instance with the same stimulus, predicts write-port
// values through a queue and the trap record through a small model.
module tb_pipeline_writeback;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_writeback_if #(.DATA_W(32), .RIDX_W(5), .DEC_EXC_W(1), .ALU_EXC_W(3),
                          .MEM_EXC_W(3), .CNT_W(4)) if0 ();
  pipeline_writeback_if #(.DATA_W(32), .RIDX_W(5), .DEC_EXC_W(1), .ALU_EXC_W(3),
                          .MEM_EXC_W(3), .CNT_W(4)) if1 ();

  assign if1.valid_in         = if0.valid_in;
  assign if1.pc_in            = if0.pc_in;
  assign if1.decode_exception = if0.decode_exception;
  assign if1.alu_exception    = if0.alu_exception;
  assign if1.mem_exception    = if0.mem_exception;
  assign if1.rd_index         = if0.rd_index;
  assign if1.regwrite_enable  = if0.regwrite_enable;
  assign if1.memread_enable   = if0.memread_enable;
  assign if1.memop_disable    = if0.memop_disable;
  assign if1.latealu_enable   = if0.latealu_enable;
  assign if1.latealu_result   = if0.latealu_result;
  assign if1.alu_out          = if0.alu_out;
  assign if1.mem_out          = if0.mem_out;
  assign if1.exc_ack          = if0.exc_ack;

  pipeline_writeback #(.DATA_W(32), .RIDX_W(5), .DEC_EXC_W(1), .ALU_EXC_W(3),
                       .MEM_EXC_W(3), .REG_OUT(0), .CNT_W(4)) u_d0 (
    .clk (clk), .rst (rst), .bus (if0.slave));

  pipeline_writeback #(.DATA_W(32), .RIDX_W(5), .DEC_EXC_W(1), .ALU_EXC_W(3),
                       .MEM_EXC_W(3), .REG_OUT(1), .CNT_W(4)) u_d1 (
    .clk (clk), .rst (rst), .bus (if1.slave));

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic        dec;
    logic [2:0]  alu;
    logic [2:0]  mem;
    logic [4:0]  rd;
    logic        rwe, mrd, mdis, late;
    logic [31:0] lres, aout, mout;
    logic        ack;
  } stim_t;

  typedef struct {
    logic        we;
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t q1[$];
  int  total = 0;
  int  bad   = 0;

  // model state
  logic        m_trapped = 1'b0;
  logic [6:0]  m_lat     = '0;
  logic [31:0] m_pc      = '0;
  logic [3:0]  m_cnt     = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] mcode(input logic [6:0] f);
    for (int i = 6; i >= 0; i--) if (f[i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic step(input stim_t s);
    logic [6:0]  ein, fin;
    logic        cap;
    wr_t         e, e1;
    @(negedge clk);
    rst                     = s.rst;
    if0.valid_in            = s.valid;
    if0.pc_in               = s.pc;
    if0.decode_exception    = s.dec;
    if0.alu_exception       = s.alu;
    if0.mem_exception       = s.mem;
    if0.rd_index            = s.rd;
    if0.regwrite_enable     = s.rwe;
    if0.memread_enable      = s.mrd;
    if0.memop_disable       = s.mdis;
    if0.latealu_enable      = s.late;
    if0.latealu_result      = s.lres;
    if0.alu_out             = s.aout;
    if0.mem_out             = s.mout;
    if0.exc_ack             = s.ack;

    ein    = s.valid ? {s.dec, s.alu, s.mem} : 7'd0;
    fin    = m_trapped ? m_lat : ein;
    cap    = !m_trapped && (ein != 7'd0);
    e.we   = s.valid && s.rwe && (fin == 7'd0) && (s.rd != 5'd0) && !m_trapped;
    e.idx  = s.rd;
    e.data = s.late ? s.lres : (s.mrd && !s.mdis) ? s.mout : s.aout;
    e1     = '{we: 1'b0, idx: 5'd0, data: 32'd0};
    if (q1.size() > 0) e1 = q1.pop_front();

    #4;
    if (!s.rst) begin
      chk("d0.final_exception", if0.final_exception, fin);
      chk("d0.exc_code",        if0.exc_code,        mcode(fin));
      chk("d0.flush",           if0.flush,           cap);
      chk("d0.exc_pending",     if0.exc_pending,     m_trapped);
      chk("d0.exc_pc",          if0.exc_pc,          m_pc);
      chk("d0.retire_count",    if0.retire_count,    m_cnt);
      chk("d0.we",              if0.we,              e.we);
      chk("d0.windex",          if0.windex,          e.idx);
      chk("d0.win",             if0.win,             e.data);
      chk("d0.fwd_valid",       if0.fwd_valid,       e.we);
      chk("d0.fwd_index",       if0.fwd_index,       e.idx);
      chk("d0.fwd_data",        if0.fwd_data,        e.data);
      chk("d1.final_exception", if1.final_exception, fin);
      chk("d1.flush",           if1.flush,           cap);
      chk("d1.exc_pending",     if1.exc_pending,     m_trapped);
      chk("d1.exc_pc",          if1.exc_pc,          m_pc);
      chk("d1.retire_count",    if1.retire_count,    m_cnt);
      chk("d1.we",              if1.we,              e1.we);
      chk("d1.windex",          if1.windex,          e1.idx);
      chk("d1.win",             if1.win,             e1.data);
      chk("d1.fwd_valid",       if1.fwd_valid,       e1.we);
      chk("d1.fwd_index",       if1.fwd_index,       e1.idx);
      chk("d1.fwd_data",        if1.fwd_data,        e1.data);
    end

    // model advances with the clock edge
    if (s.rst) begin
      m_trapped = 1'b0;
      m_lat     = '0;
      m_pc      = '0;
      m_cnt     = '0;
      q1.delete();
      q1.push_back('{we: 1'b0, idx: 5'd0, data: 32'd0});
    end else begin
      if (s.valid && (fin == 7'd0) && !m_trapped) m_cnt = m_cnt + 4'd1;
      if (cap) begin
        m_trapped = 1'b1;
        m_lat     = ein;
        m_pc      = s.pc;
      end else if (m_trapped && s.ack) begin
        m_trapped = 1'b0;
        m_lat     = '0;
        m_pc      = '0;
      end
      q1.push_back(e);
    end
  endtask

  stim_t s;

  initial begin
    s = idle(); s.rst = 1'b1;
    step(s); step(s);
    s = idle(); step(s);                                   // reset values

    // plain ALU write
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 5; s.aout = 32'h1234; s.pc = 32'h100;
    step(s);
    // LateALU beats MEM
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 6; s.late = 1; s.mrd = 1;
    s.lres = 32'hAA; s.mout = 32'hBB; s.aout = 32'hCC; step(s);
    // memop_disable forces ALU
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 7; s.mrd = 1; s.mdis = 1;
    s.aout = 32'h77; s.mout = 32'h88; step(s);
    // MEM source
    s.mdis = 0; s.rd = 8; step(s);
    // rd 0 never writes, still retires
    s.rd = 0; step(s);
    // not valid
    s.valid = 0; s.rd = 9; step(s);

    // trap capture: alu bit1 -> final 7'b0010000, code 5
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 10; s.pc = 32'h400; s.alu = 3'b010;
    s.aout = 32'h55; step(s);
    // while trapped: new exception ignored, no write, counter frozen
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 11; s.pc = 32'h404; s.mem = 3'b001; step(s);
    s.mem = 3'b000; step(s);
    // ack with a new exception present; it must be ignored
    s = idle(); s.valid = 1; s.pc = 32'h408; s.dec = 1; s.ack = 1; step(s);
    // clean instruction resumes writes
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 12; s.aout = 32'hBEEF; step(s);

    // decode bit (code 7) captured with ack in the same cycle
    s = idle(); s.valid = 1; s.pc = 32'h500; s.dec = 1; s.ack = 1; step(s);
    s = idle(); step(s);
    s = idle(); s.ack = 1; step(s);
    // ack in IDLE is ignored
    s = idle(); s.ack = 1; step(s);

    // write then mem bit0 trap next cycle; registered write still lands
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 13; s.aout = 32'h1313; step(s);
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 14; s.pc = 32'h600; s.mem = 3'b001; step(s);
    s = idle(); s.ack = 1; step(s);

    // random clean traffic, long enough to wrap the 4-bit counter
    for (int i = 0; i < 24; i++) begin
      s = idle(); s.valid = 1'($urandom_range(0, 1) | (i < 18));
      s.rwe = 1'($urandom_range(0, 1)); s.rd = 5'($urandom_range(0, 31));
      s.late = 1'($urandom_range(0, 1)); s.mrd = 1'($urandom_range(0, 1));
      s.mdis = 1'($urandom_range(0, 1)); s.lres = $urandom; s.aout = $urandom;
      s.mout = $urandom; s.pc = 32'h700 + 32'(i * 4);
      step(s);
    end

    // registered write in flight at reset is dropped
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 15; s.aout = 32'hF00D; step(s);
    s = idle(); s.rst = 1; step(s);
    s = idle(); step(s);

    // reset while trapped
    s = idle(); s.valid = 1; s.pc = 32'h800; s.alu = 3'b100; step(s);
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 3; step(s);
    s = idle(); s.rst = 1; step(s);
    s = idle(); step(s);
    s = idle(); s.valid = 1; s.rwe = 1; s.rd = 4; s.aout = 32'h44; step(s);
    s = idle(); step(s);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
